// File: rtl/uart_line_status.sv
// Line status / event generator for the APB UART: builds the 16550 LSR,
// sticky receive-error flags, RX data-available, character timeout and read-clear strobes.
module uart_line_status #(
   parameter int RX_FIFO_DEPTH = 32,
   parameter int TX_FIFO_DEPTH = 32,
   parameter int CTI_CHARS     = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             bit_tick_i,
   input  logic [1:0]                       data_bits_i,
   input  logic                             parity_en_i,
   input  logic                             stop_bits_i,
   input  logic                             rx_valid_i,
   input  logic                             rx_parity_err_i,
   input  logic                             rx_frame_err_i,
   input  logic                             rx_break_i,
   input  logic                             rx_overrun_i,
   input  logic [$clog2(RX_FIFO_DEPTH):0]   rx_elements_i,
   input  logic [$clog2(TX_FIFO_DEPTH):0]   tx_elements_i,
   input  logic                             tx_busy_i,
   input  logic                             reg_rd_i,
   input  logic [2:0]                       reg_addr_i,
   input  logic                             dlab_i,
   input  logic [3:0]                       iir_i,
   output logic [7:0]                       lsr_o,
   output logic                             error_o,
   output logic                             rda_o,
   output logic                             cti_o,
   output logic [3:0]                       clr_int_o
);

   localparam int CW = $clog2(CTI_CHARS * 12 + 1);

   logic          rbr_rd, iir_rd, lsr_rd;
   logic          oe, pe, fe, bi;
   logic          dr, thre, temt;
   logic [3:0]    char_bits;
   logic [CW-1:0] limit;
   logic [CW-1:0] cnt, cnt_next;
   logic          cnt_clr;

   assign rbr_rd = reg_rd_i && (reg_addr_i == 3'd0) && !dlab_i;
   assign iir_rd = reg_rd_i && (reg_addr_i == 3'd2);
   assign lsr_rd = reg_rd_i && (reg_addr_i == 3'd5);

   // start + data + parity + stop(s); ranges 7..12
   assign char_bits = 4'd7 + {2'b00, data_bits_i} + {3'b000, parity_en_i} + {3'b000, stop_bits_i};
   assign limit     = CW'(CTI_CHARS * int'(char_bits));
   assign cnt_clr   = rx_valid_i || rbr_rd || (rx_elements_i == '0);

   always_comb begin
      // NOTE: default assigned first so no path through this block can infer a latch.
      cnt_next = cnt;
      if (cnt_clr)
         cnt_next = '0;
      else if (bit_tick_i && (cnt < limit))
         cnt_next = cnt + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst_i) begin
         oe        <= 1'b0;
         pe        <= 1'b0;
         fe        <= 1'b0;
         bi        <= 1'b0;
         dr        <= 1'b0;
         thre      <= 1'b1;
         temt      <= 1'b1;
         rda_o     <= 1'b0;
         cnt       <= '0;
         cti_o     <= 1'b0;
         clr_int_o <= 4'b0000;
      end else begin
         // a set in the same cycle as the clearing LSR read wins
         oe        <= rx_overrun_i    || (oe && !lsr_rd);
         pe        <= rx_parity_err_i || (pe && !lsr_rd);
         fe        <= rx_frame_err_i  || (fe && !lsr_rd);
         bi        <= rx_break_i      || (bi && !lsr_rd);
         dr        <= (rx_elements_i != '0);
         thre      <= (tx_elements_i == '0);
         temt      <= (tx_elements_i == '0) && !tx_busy_i;
         rda_o     <= (rx_elements_i != '0);
         cnt       <= cnt_next;
         // >= so a shortened character format counts as already timed out
         cti_o     <= (cnt_next >= limit);
         clr_int_o <= {1'b0, lsr_rd, rbr_rd, iir_rd && (iir_i == 4'b0100)};
      end
   end

   assign lsr_o   = {pe || fe || bi, temt, thre, bi, fe, pe, oe, dr};
   assign error_o = oe || pe || fe || bi;

endmodule

// File: tb/tb_uart_line_status.sv
// Directed self-checking bench for uart_line_status: LSR stickiness, CTI timing,
// read-clear strobes and reset behaviour against hand-computed values.
module tb_uart_line_status;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       bit_tick_i;
   logic [1:0] data_bits_i;
   logic       parity_en_i;
   logic       stop_bits_i;
   logic       rx_valid_i;
   logic       rx_parity_err_i, rx_frame_err_i, rx_break_i, rx_overrun_i;
   logic [5:0] rx_elements_i;
   logic [5:0] tx_elements_i;
   logic       tx_busy_i;
   logic       reg_rd_i;
   logic [2:0] reg_addr_i;
   logic       dlab_i;
   logic [3:0] iir_i;
   logic [7:0] lsr_o;
   logic       error_o, rda_o, cti_o;
   logic [3:0] clr_int_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_line_status dut (
      .clk_i(clk), .rst_i(rst_i), .bit_tick_i(bit_tick_i), .data_bits_i(data_bits_i),
      .parity_en_i(parity_en_i), .stop_bits_i(stop_bits_i), .rx_valid_i(rx_valid_i),
      .rx_parity_err_i(rx_parity_err_i), .rx_frame_err_i(rx_frame_err_i),
      .rx_break_i(rx_break_i), .rx_overrun_i(rx_overrun_i),
      .rx_elements_i(rx_elements_i), .tx_elements_i(tx_elements_i), .tx_busy_i(tx_busy_i),
      .reg_rd_i(reg_rd_i), .reg_addr_i(reg_addr_i), .dlab_i(dlab_i), .iir_i(iir_i),
      .lsr_o(lsr_o), .error_o(error_o), .rda_o(rda_o), .cti_o(cti_o), .clr_int_o(clr_int_o)
   );

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic lsr_read();
      reg_rd_i = 1'b1; reg_addr_i = 3'd5;
      step();
      reg_rd_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; bit_tick_i = 0; data_bits_i = 2'b11; parity_en_i = 0; stop_bits_i = 0;
      rx_valid_i = 0; rx_parity_err_i = 0; rx_frame_err_i = 0; rx_break_i = 0; rx_overrun_i = 0;
      rx_elements_i = 0; tx_elements_i = 0; tx_busy_i = 0;
      reg_rd_i = 0; reg_addr_i = 0; dlab_i = 0; iir_i = 4'b0001;
      #2;
      step(2);
      check("reset_lsr", lsr_o, 8'h60);
      check("reset_error", {7'd0, error_o}, 8'd0);
      check("reset_rda", {7'd0, rda_o}, 8'd0);
      check("reset_cti", {7'd0, cti_o}, 8'd0);
      check("reset_clr", {4'd0, clr_int_o}, 8'd0);
      rst_i = 1'b0;
      step();

      // Sticky parity error, read three cycles later
      rx_parity_err_i = 1; step(); rx_parity_err_i = 0;
      check("pe_set_lsr", lsr_o, 8'hE4);
      check("pe_set_error", {7'd0, error_o}, 8'd1);
      step(2);
      check("pe_hold_lsr", lsr_o, 8'hE4);
      reg_rd_i = 1; reg_addr_i = 3'd5;
      #1 check("pe_read_preclear", lsr_o, 8'hE4);
      step(); reg_rd_i = 0;
      check("pe_read_clr", {4'd0, clr_int_o}, 8'h04);
      check("pe_cleared_lsr", lsr_o, 8'h60);
      step();
      check("pe_clr_pulse_end", {4'd0, clr_int_o}, 8'h00);

      // Frame error coincident with LSR read: set wins
      rx_frame_err_i = 1; reg_rd_i = 1; reg_addr_i = 3'd5;
      step(); rx_frame_err_i = 0; reg_rd_i = 0;
      check("fe_collide_lsr", lsr_o, 8'hE8);
      check("fe_collide_error", {7'd0, error_o}, 8'd1);
      lsr_read();
      check("fe_cleared", lsr_o, 8'h60);

      // Overrun + break together; OE does not feed bit7
      rx_overrun_i = 1; step(); rx_overrun_i = 0;
      check("oe_only_lsr", lsr_o, 8'h62);
      rx_break_i = 1; step(); rx_break_i = 0;
      check("oe_bi_lsr", lsr_o, 8'hF2);
      lsr_read();
      check("oe_bi_cleared", lsr_o, 8'h60);
      check("oe_bi_error_clr", {7'd0, error_o}, 8'd0);

      // CTI 8N1: char_bits=10, limit 40
      rx_elements_i = 3; step();
      check("rda_set", {7'd0, rda_o}, 8'd1);
      check("dr_lsr", lsr_o, 8'h61);
      bit_tick_i = 1; step(39);
      check("cti_8n1_39", {7'd0, cti_o}, 8'd0);
      step();
      check("cti_8n1_40", {7'd0, cti_o}, 8'd1);
      step(5); bit_tick_i = 0;
      check("cti_8n1_sat", {7'd0, cti_o}, 8'd1);
      reg_rd_i = 1; reg_addr_i = 3'd0; dlab_i = 0;
      #1 check("cti_before_rbr", {7'd0, cti_o}, 8'd1);
      step(); reg_rd_i = 0;
      check("rbr_clr", {4'd0, clr_int_o}, 8'h02);
      check("cti_after_rbr", {7'd0, cti_o}, 8'd0);
      dlab_i = 1; reg_rd_i = 1; step(); reg_rd_i = 0; dlab_i = 0;
      check("dlab_no_rbr_clr", {4'd0, clr_int_o}, 8'h00);

      // Shrinking the character format mid-count: 30 ticks exceeds new limit 28
      rx_valid_i = 1; step(); rx_valid_i = 0;
      bit_tick_i = 1; step(30); bit_tick_i = 0;
      check("cti_30_of_40", {7'd0, cti_o}, 8'd0);
      data_bits_i = 2'b00; step();
      check("cti_limit_shrunk", {7'd0, cti_o}, 8'd1);

      // CTI 5-bit + parity + 2 stop: char_bits=9, limit 36
      parity_en_i = 1; stop_bits_i = 1;
      rx_valid_i = 1; step(); rx_valid_i = 0;
      bit_tick_i = 1; step(35);
      check("cti_9_35", {7'd0, cti_o}, 8'd0);
      rx_valid_i = 1; step(); rx_valid_i = 0;
      check("cti_9_restart", {7'd0, cti_o}, 8'd0);
      step(35);
      check("cti_9_35b", {7'd0, cti_o}, 8'd0);
      step();
      check("cti_9_36", {7'd0, cti_o}, 8'd1);
      bit_tick_i = 0; rx_elements_i = 0; step();
      check("cti_empty_clr", {7'd0, cti_o}, 8'd0);
      check("rda_clr", {7'd0, rda_o}, 8'd0);

      // Reset mid-count and with a coincident error pulse
      data_bits_i = 2'b11; parity_en_i = 0; stop_bits_i = 0; rx_elements_i = 3;
      bit_tick_i = 1; step(20);
      rst_i = 1; rx_parity_err_i = 1; step(); rst_i = 0; rx_parity_err_i = 0;
      check("midrst_lsr", lsr_o, 8'h60);
      check("midrst_error", {7'd0, error_o}, 8'd0);
      step(39);
      check("midrst_cnt_39", {7'd0, cti_o}, 8'd0);
      step();
      check("midrst_cnt_40", {7'd0, cti_o}, 8'd1);
      bit_tick_i = 0; rx_elements_i = 0; step();

      // IIR read clears THRE only when IIR shows THRE interrupt
      reg_rd_i = 1; reg_addr_i = 3'd2; iir_i = 4'b0100; step();
      check("iir_thre_clr", {4'd0, clr_int_o}, 8'h01);
      iir_i = 4'b1000; step(); reg_rd_i = 0;
      check("iir_other_clr", {4'd0, clr_int_o}, 8'h00);

      // Back-to-back LSR reads give back-to-back pulses
      reg_rd_i = 1; reg_addr_i = 3'd5; step();
      check("b2b_lsr_1", {4'd0, clr_int_o}, 8'h04);
      step(); reg_rd_i = 0;
      check("b2b_lsr_2", {4'd0, clr_int_o}, 8'h04);

      // THRE / TEMT
      tx_busy_i = 1; step();
      check("temt_busy", {6'd0, lsr_o[6:5]}, 8'h01);
      tx_busy_i = 0; tx_elements_i = 5; step();
      check("tx_nonempty_lsr", lsr_o, 8'h00);
      tx_elements_i = 0; step();
      check("tx_idle_lsr", lsr_o, 8'h60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
